mem_copy_engine: RTL and testbench

Bus-master block that drives the single-port RAM16K data-memory interface (address / in / load, combinational out) to perform block copy and block fill without CPU involvement. It sits between the control logic and a RAM16K instance. It owns that instance's port while busy, sequencing read-then-write word transfers. It reports progress and completion to the requester.

---
 rtl/mem_copy_engine.sv | 181 ++++++++++++++++++
 tb/tb_mem_copy_engine.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
`default_nettype none
// ============================================================================
// Module      : mem_copy_engine
// Description : Bus master for a single-port RAM16K data memory. Performs
//               ascending block copy (read-then-write per word) or block fill
//               without CPU involvement, and reports progress and completion.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_copy_engine #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] CNT_ZERO = '0;

  logic [1:0]        state;
  logic [1:0]        state_nx;

  // Request parameters captured when a start is accepted.
  logic              mode_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W:0]   len_q;
  logic [DATA_W-1:0] fill_q;

  // Next values for every registered output.
  logic              busy_nx;
  logic              done_nx;
  logic              load_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] din_nx;
  logic [ADDR_W:0]   count_nx;
  logic              accept;

  // count doubles as the word index i; only its low ADDR_W bits take part in
  // address arithmetic, so src+i / dst+i wrap naturally modulo 2^ADDR_W.
  logic [ADDR_W:0]   count_inc;
  logic [ADDR_W-1:0] idx_cur;
  logic [ADDR_W-1:0] idx_nxt;
  logic              last_write;

  assign count_inc  = count + CNT_ONE;
  assign idx_cur    = count[ADDR_W-1:0];
  assign idx_nxt    = count_inc[ADDR_W-1:0];
  assign last_write = (count_inc == len_q);
  assign accept     = (state == IDLE) && start;

  // Next-state and next-output decode; every RAM port signal leaves a flop.
  always_comb begin
    state_nx = state;
    busy_nx  = busy;
    done_nx  = 1'b0;
    load_nx  = 1'b0;
    addr_nx  = mem_address;
    din_nx   = mem_in;
    count_nx = count;
    case (state)
      IDLE: begin
        busy_nx = 1'b0;
        if (start) begin
          count_nx = CNT_ZERO;
          if (len == CNT_ZERO) begin
            // Empty request completes at once and never touches the port.
            state_nx = DONE;
            done_nx  = 1'b1;
          end else if (mode) begin
            state_nx = WRITE;
            busy_nx  = 1'b1;
            load_nx  = 1'b1;
            addr_nx  = dst;
            din_nx   = fill_value;
          end else begin
            state_nx = READ;
            busy_nx  = 1'b1;
            addr_nx  = src;
          end
        end
      end
      READ: begin
        if (abort) begin
          // The word being read is dropped; nothing more is written.
          state_nx = DONE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end else begin
          state_nx = WRITE;
          load_nx  = 1'b1;
          addr_nx  = dst_q + idx_cur;
          din_nx   = mem_out;
        end
      end
      WRITE: begin
        // The write presented this cycle always lands, so it is always counted.
        count_nx = count_inc;
        if (abort || last_write) begin
          state_nx = DONE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end else if (mode_q) begin
          load_nx  = 1'b1;
          addr_nx  = dst_q + idx_nxt;
          din_nx   = fill_q;
        end else begin
          state_nx = READ;
          addr_nx  = src_q + idx_nxt;
        end
      end
      DONE: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
      default: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops the RAM port immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_load    <= 1'b0;
      mem_address <= '0;
      mem_in      <= '0;
      count       <= '0;
    end else begin
      state       <= state_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      mem_load    <= load_nx;
      mem_address <= addr_nx;
      mem_in      <= din_nx;
      count       <= count_nx;
    end
  end

  // Request capture; only a start seen in IDLE updates these.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      fill_q <= '0;
    end else if (accept) begin
      mode_q <= mode;
      src_q  <= src;
      dst_q  <= dst;
      len_q  <= len;
      fill_q <= fill_value;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_copy_engine
// Description : Self-checking bench for mem_copy_engine with a RAM16K model
//               and an array-based reference of expected memory contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_copy_engine;

  localparam int AW    = 14;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] src = '0;
  logic [AW-1:0] dst = '0;
  logic [AW:0]   len = '0;
  logic [DW-1:0] fill_value = '0;
  logic          abort = 1'b0;
  logic          busy;
  logic          done;
  logic [AW:0]   count;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_in;
  logic          mem_load;
  logic [DW-1:0] mem_out;

  int errors = 0;
  int checks = 0;
  int bad_load = 0;

  always #5 clk = ~clk;

  mem_copy_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_value(fill_value), .abort(abort), .busy(busy), .done(done),
    .count(count), .mem_address(mem_address), .mem_in(mem_in),
    .mem_load(mem_load), .mem_out(mem_out)
  );

  // RAM16K model: combinational read, write on the rising edge when load=1.
  logic [DW-1:0] ram  [0:DEPTH-1];
  logic [DW-1:0] refm [0:DEPTH-1];
  logic          init_req = 1'b0;
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  assign mem_out = ram[mem_address];

  function automatic logic [DW-1:0] init_word(input int i);
    return DW'((i * 40503 + 12345) ^ (i >> 3));
  endfunction

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
    end else begin
      if (mem_load) ram[mem_address] <= mem_in;
      if (bd_we) ram[bd_addr] <= bd_data;
    end
  end

  // A write strobe outside a busy period is never legal.
  always @(negedge clk) if (rst_n && mem_load && !busy) bad_load++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int mem_diffs();
    int n;
    n = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== refm[i]) n++;
    return n;
  endfunction

  task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] v);
    bd_we = 1'b1; bd_addr = a; bd_data = v;
    tick();
    bd_we = 1'b0;
    refm[a] = v;
  endtask

  // One request: the reference outcome comes from the timing and ordering
  // rules, then the DUT run is observed cycle by cycle and compared.
  task automatic run_op(input string name, input bit m, input logic [AW-1:0] s,
                        input logic [AW-1:0] d, input logic [AW:0] n,
                        input logic [DW-1:0] fv, input int abort_cyc, input int poke_cyc);
    int busy_total, exp_done, exp_words, cyc, done_cyc, writes, busy_cnt, a;
    logic done_busy, done_load;
    busy_total = (n == 0) ? 0 : (m ? int'(n) : 2 * int'(n));
    if (abort_cyc >= 1 && abort_cyc <= busy_total) begin
      exp_done  = abort_cyc + 1;
      exp_words = m ? abort_cyc : abort_cyc / 2;
    end else begin
      exp_done  = busy_total + 1;
      exp_words = int'(n);
    end
    for (int i = 0; i < exp_words; i++) begin
      a = (int'(d) + i) % DEPTH;
      refm[a] = m ? fv : refm[(int'(s) + i) % DEPTH];
    end

    start = 1'b1; mode = m; src = s; dst = d; len = n; fill_value = fv;
    tick();
    start = 1'b0;
    mode = 1'($urandom); src = AW'($urandom); dst = AW'($urandom);
    len = (AW+1)'($urandom); fill_value = DW'($urandom);

    cyc = 1; done_cyc = 0; writes = 0; busy_cnt = 0;
    done_busy = 1'b1; done_load = 1'b1;
    while (cyc <= exp_done + 4 && done_cyc == 0) begin
      if (done) begin
        done_cyc  = cyc;
        done_busy = busy;
        done_load = mem_load;
      end else begin
        if (busy) busy_cnt++;
        if (mem_load) writes++;
        abort = (cyc == abort_cyc);
        start = (cyc == poke_cyc);
        tick();
        cyc++;
      end
    end
    abort = 1'b0; start = 1'b0;

    check({name, " done_cycle"}, done_cyc, exp_done);
    check({name, " busy_cycles"}, busy_cnt, exp_done - 1);
    check({name, " writes"}, writes, exp_words);
    check({name, " count"}, 32'(count), exp_words);
    check({name, " idle_at_done"}, {30'd0, done_busy, done_load}, 0);
    tick();
    check({name, " done_pulse"}, 32'(done), 0);
    check({name, " count_held"}, 32'(count), exp_words);
    check({name, " memory"}, mem_diffs(), 0);
  endtask

  initial begin
    int bt, n, ac, pk;
    bit m;
    logic [AW-1:0] s, d;

    rst_n = 1'b0;
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) refm[i] = init_word(i);
    tick();
    check("reset outputs", {busy, done, mem_load, 13'd0}, 0);
    check("reset addr_data_count", {mem_address, mem_in, 2'b00} | 32'(count), 0);
    rst_n = 1'b1;
    tick();

    // Directed copy.
    bd_write(14'd100, 16'h00A1); bd_write(14'd101, 16'h00B2);
    bd_write(14'd102, 16'h00C3); bd_write(14'd103, 16'h00D4);
    run_op("copy4", 1'b0, 14'd100, 14'd200, 15'd4, 16'h0, 0, 0);
    check("copy4 dst0", 32'(ram[200]), 32'h00A1);
    check("copy4 dst3", 32'(ram[203]), 32'h00D4);
    check("copy4 src1", 32'(ram[101]), 32'h00B2);

    // Fill wrapping past the top of memory.
    run_op("fillwrap", 1'b1, 14'd0, 14'd16382, 15'd4, 16'hBEEF, 0, 0);
    check("fillwrap 16383", 32'(ram[16383]), 32'hBEEF);
    check("fillwrap 1", 32'(ram[1]), 32'hBEEF);
    check("fillwrap 2", 32'(ram[2]), 32'(refm[2]));

    // Empty request.
    run_op("zero", 1'b0, 14'd5, 14'd6, 15'd0, 16'h0, 0, 0);

    // Abort on the third write, with a start poked while busy.
    run_op("abort_wr", 1'b0, 14'd500, 14'd600, 15'd10, 16'h0, 6, 3);
    // Abort on the third read: only two words land.
    run_op("abort_rd", 1'b0, 14'd700, 14'd800, 15'd6, 16'h0, 5, 0);

    // Overlapping forward copy propagates the first word.
    bd_write(14'd10, 16'd1); bd_write(14'd11, 16'd2); bd_write(14'd12, 16'd3);
    run_op("overlap", 1'b0, 14'd10, 14'd11, 15'd2, 16'h0, 0, 0);
    check("overlap 11", 32'(ram[11]), 1);
    check("overlap 12", 32'(ram[12]), 1);

    // Reset during the second read of a 5-word copy.
    start = 1'b1; mode = 1'b0; src = 14'd300; dst = 14'd400; len = 15'd5;
    tick();
    start = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("midreset flags", {29'd0, busy, done, mem_load}, 0);
    check("midreset addr_count", {mem_address, 3'b000} | 32'(count), 0);
    check("midreset data", 32'(mem_in), 0);
    refm[400] = refm[300];
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("midreset memory", mem_diffs(), 0);
    run_op("after_reset", 1'b0, 14'd300, 14'd400, 15'd5, 16'h0, 0, 0);

    // Randomized requests, including wrap, overlap and aborts.
    for (int t = 0; t < 14; t++) begin
      m = 1'($urandom);
      n = ($urandom % 8 == 0) ? 0 : 1 + int'($urandom % 40);
      s = AW'($urandom);
      d = ($urandom % 3 == 0) ? AW'(s + AW'($urandom % 4)) : AW'($urandom);
      if (t == 3) d = AW'(DEPTH - 5);
      bt = (n == 0) ? 0 : (m ? n : 2 * n);
      ac = (bt > 0 && $urandom % 4 == 0) ? 1 + int'($urandom % bt) : 0;
      pk = (bt > 2) ? 2 + int'($urandom % (bt - 1)) : 0;
      run_op($sformatf("rnd%0d", t), m, s, d, (AW+1)'(n), DW'($urandom), ac, pk);
    end

    // Full-memory fill: every address written exactly once.
    run_op("full_fill", 1'b1, 14'd0, AW'($urandom), 15'd16384, 16'h5A3C, 0, 0);

    check("no load outside busy", bad_load, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
